// File: rtl/coin_input_filter.sv
// Coin-sensor front end: two-flop synchronisers, press/release debounce FSMs and
// a one-hot pulse arbiter feeding a saturating running total in half-yuan units.
module coin_input_filter #(
  parameter logic [19:0] CNT_MAX = 20'd999_999,
  parameter int          TOTAL_W = 8
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               key_one,
  input  logic               key_half,
  output logic               po_money_one,
  output logic               po_money_half,
  output logic [TOTAL_W-1:0] po_total
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] PRESS_FLT = 2'd1;
  localparam logic [1:0] PRESSED   = 2'd2;
  localparam logic [1:0] REL_FLT   = 2'd3;
  localparam int         CW        = $bits(CNT_MAX);

  // Channel index 0 is the one-yuan sensor, index 1 the half-yuan sensor.
  logic [1:0]    raw;
  logic [1:0]    sync1;
  logic [1:0]    level;
  logic [1:0]    state     [2];
  logic [1:0]    state_nxt [2];
  logic [CW-1:0] cnt       [2];
  logic [CW-1:0] cnt_nxt   [2];
  logic [1:0]    req;

  logic               pending;
  logic               pending_nxt;
  logic               fire_one;
  logic               fire_half;
  logic [1:0]         inc;
  logic [TOTAL_W:0]   sum;
  logic [TOTAL_W-1:0] total_nxt;

  assign raw = {key_half, key_one};

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      state_nxt[c] = state[c];
      cnt_nxt[c]   = cnt[c];
      req[c]       = 1'b0;
      case (state[c])
        IDLE: begin
          if (!level[c]) begin
            state_nxt[c] = PRESS_FLT;
            cnt_nxt[c]   = '0;
          end
        end
        PRESS_FLT: begin
          if (level[c]) begin
            state_nxt[c] = IDLE;
            cnt_nxt[c]   = '0;
          end else if (cnt[c] == CNT_MAX) begin
            state_nxt[c] = PRESSED;
            cnt_nxt[c]   = '0;
            req[c]       = 1'b1;
          end else begin
            cnt_nxt[c] = cnt[c] + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        PRESSED: begin
          if (level[c]) begin
            state_nxt[c] = REL_FLT;
            cnt_nxt[c]   = '0;
          end
        end
        default: begin
          // Release bounce drops back to PRESSED without re-arming the channel.
          if (!level[c]) begin
            state_nxt[c] = PRESSED;
            cnt_nxt[c]   = '0;
          end else if (cnt[c] == CNT_MAX) begin
            state_nxt[c] = IDLE;
            cnt_nxt[c]   = '0;
          end else begin
            cnt_nxt[c] = cnt[c] + {{(CW-1){1'b0}}, 1'b1};
          end
        end
      endcase
    end
  end

  // One-yuan always wins the cycle; a half-yuan request that collides with it
  // waits in pending until the first cycle without a one-yuan request.
  assign fire_one    = req[0];
  assign fire_half   = !req[0] && (pending || req[1]);
  assign pending_nxt = req[0] && (pending || req[1]);

  assign inc       = {fire_one, fire_half};
  assign sum       = {1'b0, po_total} + {{(TOTAL_W-1){1'b0}}, inc};
  assign total_nxt = sum[TOTAL_W] ? {TOTAL_W{1'b1}} : sum[TOTAL_W-1:0];

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync1         <= 2'b11;
      level         <= 2'b11;
      for (int c = 0; c < 2; c++) begin
        state[c] <= IDLE;
        cnt[c]   <= '0;
      end
      pending       <= 1'b0;
      po_money_one  <= 1'b0;
      po_money_half <= 1'b0;
      po_total      <= '0;
    end else begin
      sync1         <= raw;
      level         <= sync1;
      for (int c = 0; c < 2; c++) begin
        state[c] <= state_nxt[c];
        cnt[c]   <= cnt_nxt[c];
      end
      pending       <= pending_nxt;
      po_money_one  <= fire_one;
      po_money_half <= fire_half;
      po_total      <= total_nxt;
    end
  end

endmodule
